// File: rtl/calc_display_driver.sv
// Scans an 8-digit common-anode 7-segment display: digits 3..0 show a per-frame snapshot
// of ToDisplay in hex, and digit 7 shows Status. Defining LEADING_ZERO_BLANK_EN blanks leading zeros.
module calc_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ToDisplay,
  input  logic [4:0]  Flags,
  input  logic [2:0]  Status,
  output logic [6:0]  Segments,
  output logic [7:0]  Anodes,
  output logic        Dp,
  output logic [4:0]  Leds
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [15:0]   snapshot_q, snapshot_d;
  logic [2:0]    status_q, status_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [4:0]    leds_q;
  logic          tick, frame_start, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick        = (div_cnt_q == CW'(REFRESH_DIV - 1));
  // The snapshot is taken on the same edge the scan wraps to digit 0, so a whole frame is coherent.
  assign frame_start = tick && (digit_idx_q == 3'd7);

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    snapshot_d  = frame_start ? ToDisplay : snapshot_q;
    status_d    = frame_start ? Status : status_q;
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    case (digit_idx_q)
      3'd0: nib = snapshot_q[3:0];
      3'd1: begin
        nib   = snapshot_q[7:4];
        blank = LZB && (snapshot_q[15:4] == 12'h000);
      end
      3'd2: begin
        nib   = snapshot_q[11:8];
        blank = LZB && (snapshot_q[15:8] == 8'h00);
      end
      3'd3: begin
        nib   = snapshot_q[15:12];
        blank = LZB && (snapshot_q[15:12] == 4'h0);
      end
      3'd7:    nib   = {1'b0, status_q};
      default: blank = 1'b1;
    endcase
    seg_d = blank ? 7'h7F : hex7(nib);
    an_d  = ~(8'b1 << digit_idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 3'd0;
      snapshot_q  <= 16'h0000;
      status_q    <= 3'd0;
      seg_q       <= 7'h7F;
      an_q        <= 8'hFF;
      leds_q      <= 5'd0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      snapshot_q  <= snapshot_d;
      status_q    <= status_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      leds_q      <= Flags;
    end
  end

  assign Segments = seg_q;
  assign Anodes   = an_q;
  assign Leds     = leds_q;
  assign Dp       = 1'b1;

endmodule
